// File: rtl/board_renderer.sv
// board_renderer: draws an 8x8 board of 15x15-pixel squares from a piece-code memory,
// either the whole board in row-major order or a single requested square.
module board_renderer (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       start_square,
    input  logic [2:0] sq_x,
    input  logic [2:0] sq_y,
    output logic [2:0] mem_x,
    output logic [2:0] mem_y,
    input  logic [3:0] mem_data,
    output logic [7:0] vga_x,
    output logic [6:0] vga_y,
    output logic [2:0] vga_colour,
    output logic       plot,
    output logic       busy,
    output logic       done
);
    typedef enum logic [2:0] {IDLE, ADDR, WAIT, LATCH, DRAW, NEXT, DONE} state_t;
    state_t     state_q, state_d;
    logic [2:0] col_q, col_d, row_q, row_d;
    logic [3:0] px_q, px_d, py_q, py_d, piece_q, piece_d;
    logic       single_q, single_d;
    logic       inner, draw;
    logic [2:0] ring_c, piece_c;
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            col_q    <= '0;
            row_q    <= '0;
            px_q     <= '0;
            py_q     <= '0;
            piece_q  <= '0;
            single_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            col_q    <= col_d;
            row_q    <= row_d;
            px_q     <= px_d;
            py_q     <= py_d;
            piece_q  <= piece_d;
            single_q <= single_d;
        end
    end
    always_comb begin
        state_d  = state_q;
        col_d    = col_q;
        row_d    = row_q;
        px_d     = px_q;
        py_d     = py_q;
        piece_d  = piece_q;
        single_d = single_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    col_d    = '0;
                    row_d    = '0;
                    single_d = 1'b0;
                    state_d  = ADDR;
                end else if (start_square) begin
                    col_d    = sq_x;
                    row_d    = sq_y;
                    single_d = 1'b1;
                    state_d  = ADDR;
                end
            end
            ADDR:  state_d = WAIT;
            WAIT:  state_d = LATCH;
            LATCH: begin
                piece_d = mem_data;
                px_d    = '0;
                py_d    = '0;
                state_d = DRAW;
            end
            DRAW: begin
                px_d    = (px_q == 4'd14) ? 4'd0 : px_q + 4'd1;
                py_d    = (px_q == 4'd14) ? py_q + 4'd1 : py_q;
                state_d = (px_q == 4'd14 && py_q == 4'd14) ? NEXT : DRAW;
            end
            NEXT: begin
                if (single_q || (col_q == 3'd7 && row_q == 3'd7)) begin
                    state_d = DONE;
                end else begin
                    col_d   = col_q + 3'd1;
                    row_d   = (col_q == 3'd7) ? row_q + 3'd1 : row_q;
                    state_d = ADDR;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end
    always_comb begin
        draw       = (state_q == DRAW);
        inner      = (px_q >= 4'd3) && (px_q <= 4'd11) && (py_q >= 4'd3) && (py_q <= 4'd11);
        ring_c     = (col_q[0] ^ row_q[0]) ? 3'b010 : 3'b110;
        piece_c    = (piece_q == 4'd0) ? ring_c : (piece_q <= 4'd6) ? 3'b000 : (piece_q <= 4'd12) ? 3'b111 : 3'b100;
        mem_x      = col_q;
        mem_y      = row_q;
        plot       = draw;
        busy       = (state_q != IDLE);
        done       = (state_q == DONE);
        vga_x      = draw ? 8'd20 + 8'd15 * {5'b0, col_q} + {4'b0, px_q} : 8'd0;
        vga_y      = draw ? 7'd15 * {4'b0, row_q} + {3'b0, py_q} : 7'd0;
        vga_colour = draw ? (inner ? piece_c : ring_c) : 3'b000;
    end
endmodule

// File: tb/tb_board_renderer.sv
// tb_board_renderer: randomized and directed scoreboard bench; expected pixels and done
// events are queued at stimulus time and a negedge monitor checks what the renderer emits.
module tb_board_renderer;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       start_square = 1'b0;
    logic [2:0] sq_x = '0, sq_y = '0;
    logic [2:0] mem_x, mem_y;
    logic [3:0] mem_data = '0;
    logic [7:0] vga_x;
    logic [6:0] vga_y;
    logic [2:0] vga_colour;
    logic       plot, busy, done;

    board_renderer dut (
        .clk(clk), .reset(reset), .start(start), .start_square(start_square),
        .sq_x(sq_x), .sq_y(sq_y), .mem_x(mem_x), .mem_y(mem_y), .mem_data(mem_data),
        .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour),
        .plot(plot), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {int x; int y; int c;} pix_t;
    typedef struct {int cyc; int plots;} dn_t;
    pix_t pq[$];
    dn_t  dq[$];
    logic [3:0] mem [0:63];
    logic [2:0] fb [0:255][0:127];
    int errors = 0, checks = 0, cyc = 0, pcount = 0;
    bit noise = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string n, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d", n, got, exp);
        end
    endtask

    // Reference colour straight from the board rules: ring/empty shows the square shade.
    function automatic int colour(input int code, input int col, input int row, input int px, input int py);
        bit in9 = px >= 3 && px <= 11 && py >= 3 && py <= 11;
        int shade = ((col + row) % 2 == 0) ? 6 : 2;
        if (code == 0 || !in9) return shade;
        if (code <= 6) return 0;
        if (code <= 12) return 7;
        return 4;
    endfunction

    task automatic push_square(input int col, input int row);
        for (int py = 0; py < 15; py++)
            for (int px = 0; px < 15; px++)
                pq.push_back('{20 + 15 * col + px, 15 * row + py, colour(int'(mem[row * 8 + col]), col, row, px, py)});
    endtask

    // Memory: normal mode returns data one cycle after the address; noise mode returns
    // garbage except in the cycle the address has been stable for two cycles.
    logic [5:0] pa = '0;
    bit pbusy = 1'b0;
    int k = 0;
    always @(negedge clk) begin
        logic [5:0] a;
        a = {mem_y, mem_x};
        if ((busy && !pbusy) || a != pa) k = 0;
        else if (k < 3) k++;
        mem_data = noise ? ((k == 2) ? mem[a] : 4'($urandom)) : mem[pa];
        pa = a;
        pbusy = busy;
    end

    always @(negedge clk) begin
        pix_t e;
        dn_t d;
        if (plot) begin
            pcount++;
            fb[vga_x][vga_y] = vga_colour;
            checks++;
            if (pq.size() == 0) begin
                errors++;
                $display("FAIL unexpected_plot got x=%0d y=%0d c=%0d exp none", vga_x, vga_y, vga_colour);
            end else begin
                e = pq.pop_front();
                if (int'(vga_x) != e.x || int'(vga_y) != e.y || int'(vga_colour) != e.c) begin
                    errors++;
                    $display("FAIL pixel got x=%0d y=%0d c=%0d exp x=%0d y=%0d c=%0d",
                             vga_x, vga_y, vga_colour, e.x, e.y, e.c);
                end
            end
        end
        if (done) begin
            if (dq.size() == 0) begin
                chk("unexpected_done", 1, 0);
            end else begin
                d = dq.pop_front();
                chk("done_cycle", cyc, d.cyc);
                chk("plot_count", pcount, d.plots);
            end
            pcount = 0;
        end
    end

    task automatic full_redraw(input bit both);
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++) push_square(c, r);
        dq.push_back('{cyc + 14657, 14400});
        start = 1'b1;
        start_square = both;
        sq_x = 3'($urandom);
        sq_y = 3'($urandom);
        @(negedge clk);
        start = 1'b0;
        start_square = 1'b0;
    endtask

    task automatic single(input int x, input int y);
        push_square(x, y);
        dq.push_back('{cyc + 230, 225});
        sq_x = 3'(x);
        sq_y = 3'(y);
        start_square = 1'b1;
        @(negedge clk);
        start_square = 1'b0;
        sq_x = 3'($urandom);
        sq_y = 3'($urandom);
    endtask

    task automatic wait_idle(input int max);
        for (int i = 0; i < max && busy; i++) @(negedge clk);
        if (busy) begin
            chk("idle_timeout", 1, 0);
            $display("FAIL timeout waiting for idle");
            $display("Result: errors=%0d of %0d checks", errors, checks);
            $fatal(1);
        end
        @(negedge clk);
    endtask

    task automatic check_reset_state();
        chk("rst_plot", plot, 0);
        chk("rst_done", done, 0);
        chk("rst_busy", busy, 0);
        chk("rst_mem_xy", {mem_x, mem_y}, 0);
        chk("rst_vga_xy", {vga_x, vga_y}, 0);
        chk("rst_colour", vga_colour, 0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        start = 1'b1;
        start_square = 1'b1;
        @(posedge clk);
        #1;
        pq.delete();
        dq.delete();
        pcount = 0;
        @(negedge clk);
        reset = 1'b0;
        start = 1'b0;
        start_square = 1'b0;
        check_reset_state();
    endtask

    initial begin
        int init_row [8] = '{4, 2, 3, 5, 6, 3, 2, 4};
        for (int i = 0; i < 64; i++) mem[i] = 4'd0;
        for (int x = 0; x < 256; x++)
            for (int y = 0; y < 128; y++) fb[x][y] = 3'd5;
        for (int c = 0; c < 8; c++) begin
            mem[c]      = 4'(init_row[c]);
            mem[8 + c]  = 4'd1;
            mem[48 + c] = 4'd7;
            mem[56 + c] = 4'(init_row[c] + 6);
        end
        @(negedge clk);
        do_reset();
        full_redraw(1'b0);
        wait_idle(20000);
        chk("px_20_0", fb[20][0], 6);
        chk("px_23_3", fb[23][3], 0);
        chk("px_23_108", fb[23][108], 7);
        chk("px_35_30", fb[35][30], 2);

        mem[3 * 8 + 4] = 4'd11;
        single(4, 3);
        wait_idle(1000);
        chk("sq43_inner", fb[87][52], 7);
        chk("sq43_ring", fb[80][45], 2);

        mem[0] = 4'd14;
        single(0, 0);
        wait_idle(1000);
        chk("sq00_inner", fb[24][4], 4);
        chk("sq00_ring", fb[20][0], 6);

        full_redraw(1'b1);
        repeat (3000) @(negedge clk);
        start = 1'b1;
        start_square = 1'b1;
        @(negedge clk);
        start = 1'b0;
        start_square = 1'b0;
        wait_idle(20000);

        full_redraw(1'b0);
        repeat (10 * 229 + 100) @(negedge clk);
        do_reset();
        repeat (20) @(negedge clk);
        chk("post_abort_busy", busy, 0);

        noise = 1'b1;
        for (int i = 0; i < 64; i++) mem[i] = 4'($urandom);
        full_redraw(1'b0);
        wait_idle(20000);
        for (int n = 0; n < 12; n++) begin
            mem[$urandom_range(63)] = 4'($urandom);
            single(int'($urandom_range(7)), int'($urandom_range(7)));
            wait_idle(1000);
        end
        noise = 1'b0;
        chk("pending_pixels", pq.size(), 0);
        chk("pending_done", dq.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
